// File: rtl/ysyx_23060184_rf_scoreboard.sv
// Integer register file with a per-register busy scoreboard that stalls issue on RAW/WAW hazards.
// Optional feature macro RF_BYPASS_EN: forwards writeback data to reads and releases hazards in the writeback cycle.
module ysyx_23060184_rf_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int ECALL_REG  = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    input  logic                  ecall,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_done,
    output logic                  wb_orphan
);
    localparam int NREGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ECALL_IDX = ADDR_WIDTH'(ECALL_REG);

    logic [DATA_WIDTH-1:0] rf_q [NREGS];
    logic [DATA_WIDTH-1:0] rf_d [NREGS];
    logic [NREGS-1:0]      busy_q;
    logic [NREGS-1:0]      busy_d;
    logic [NREGS-1:0]      busy_eff;
    logic                  wb_done_q, wb_done_d;
    logic                  wb_orphan_q, wb_orphan_d;
    logic [ADDR_WIDTH-1:0] raddr2_eff;
    logic                  wb_en;
    logic                  issue_fire;

    assign wb_en      = wb_valid && (wb_addr != '0);
    assign raddr2_eff = ecall ? ECALL_IDX : raddr2;

`ifdef RF_BYPASS_EN
    logic [NREGS-1:0] wb_hit;

    always_comb begin
        wb_hit = '0;
        if (wb_en) wb_hit[wb_addr] = 1'b1;
    end

    // A register retiring this cycle no longer blocks its consumer.
    assign busy_eff = busy_q & ~wb_hit;
`else
    assign busy_eff = busy_q;
`endif

    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : rf_q[raddr1];
        rdata2 = (raddr2_eff == '0) ? '0 : rf_q[raddr2_eff];
`ifdef RF_BYPASS_EN
        if (wb_en && (raddr1 == wb_addr)) rdata1 = wb_data;
        if (wb_en && (raddr2_eff == wb_addr)) rdata2 = wb_data;
`endif
    end

    // busy_q[0] is never set, so index 0 can never raise a hazard.
    assign issue_ready = !busy_eff[raddr1] && !busy_eff[raddr2_eff] && !busy_eff[issue_rd];
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);

    always_comb begin
        rf_d        = rf_q;
        busy_d      = busy_q;
        wb_done_d   = wb_en;
        wb_orphan_d = wb_en && !busy_q[wb_addr];
        if (wb_en) begin
            rf_d[wb_addr]   = wb_data;
            busy_d[wb_addr] = 1'b0;
        end
        // Applied after the writeback clear so a same-index reservation wins.
        if (issue_fire) busy_d[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
            busy_q      <= '0;
            wb_done_q   <= 1'b0;
            wb_orphan_q <= 1'b0;
        end else begin
            rf_q        <= rf_d;
            busy_q      <= busy_d;
            wb_done_q   <= wb_done_d;
            wb_orphan_q <= wb_orphan_d;
        end
    end

    assign wb_done   = wb_done_q;
    assign wb_orphan = wb_orphan_q;
endmodule

// File: tb/tb_ysyx_23060184_rf_scoreboard.sv
// Bench for ysyx_23060184_rf_scoreboard: directed scenarios plus random traffic against a behavioural model.
module tb_ysyx_23060184_rf_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  raddr1, raddr2, issue_rd, wb_addr;
  logic [31:0] rdata1, rdata2, wb_data;
  logic        ecall, issue_valid, issue_ready, wb_valid, wb_done, wb_orphan;

  int n_checks = 0;
  int n_errors = 0;
  bit run_cmp = 1'b0;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  ysyx_23060184_rf_scoreboard #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .ECALL_REG(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .ecall(ecall),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_done(wb_done), .wb_orphan(wb_orphan)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural model: register contents, busy set, expected pulses
  logic [31:0] m_rf [32];
  bit   [31:0] m_busy;
  bit          m_done, m_orphan;

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (BYP && wb_valid && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic bit hazard(input logic [4:0] a);
    if (a == 5'd0 || !m_busy[a]) return 1'b0;
    if (BYP && wb_valid && wb_addr == a) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [4:0] port2_addr();
    return ecall ? 5'd15 : raddr2;
  endfunction

  function automatic bit exp_ready();
    return !(hazard(raddr1) || hazard(port2_addr()) || hazard(issue_rd));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_rf[i] <= 32'd0;
      m_busy   <= '0;
      m_done   <= 1'b0;
      m_orphan <= 1'b0;
    end else begin
      m_done   <= wb_valid && wb_addr != 5'd0;
      m_orphan <= wb_valid && wb_addr != 5'd0 && !m_busy[wb_addr];
      if (wb_valid && wb_addr != 5'd0) begin
        m_rf[wb_addr]   <= wb_data;
        m_busy[wb_addr] <= 1'b0;
      end
      if (issue_valid && exp_ready() && issue_rd != 5'd0) m_busy[issue_rd] <= 1'b1;
    end
  end

  // scoreboard
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && run_cmp) begin
      chk("cmp_rdata1", rdata1, exp_rd(raddr1));
      chk("cmp_rdata2", rdata2, exp_rd(port2_addr()));
      chk("cmp_issue_ready", {31'd0, issue_ready}, {31'd0, exp_ready()});
      chk("cmp_wb_done", {31'd0, wb_done}, {31'd0, m_done});
      chk("cmp_wb_orphan", {31'd0, wb_orphan}, {31'd0, m_orphan});
    end
  end

  // driver tasks
  task automatic idle();
    raddr1 = 0; raddr2 = 0; ecall = 0;
    issue_valid = 0; issue_rd = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic at_check();
    @(negedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_valid = 1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_cmp = 1'b1;

    // reset mid-stream
    next_cyc(); wb(5'd5, 32'hDEADBEEF); issue_valid = 1; issue_rd = 5'd6;
    next_cyc(); wb(5'd8, 32'h0000_1111); raddr1 = 5'd5; raddr2 = 5'd6;
    at_check();
    chk("pre_rst_rdata1", rdata1, 32'hDEADBEEF);
    chk("pre_rst_ready", {31'd0, issue_ready}, 32'd0);
    chk("pre_rst_done", {31'd0, wb_done}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_ready", {31'd0, issue_ready}, 32'd1);
    chk("rst_done", {31'd0, wb_done}, 32'd0);
    chk("rst_orphan", {31'd0, wb_orphan}, 32'd0);
    next_cyc();
    rst_n = 1'b1;
    raddr1 = 5'd8; raddr2 = 5'd6; issue_rd = 5'd6;
    at_check();
    chk("rst_inflight_dropped", rdata1, 32'd0);
    chk("rst_busy_clear", {31'd0, issue_ready}, 32'd1);

    // x0
    next_cyc(); wb(5'd0, 32'hFFFFFFFF); issue_valid = 1; issue_rd = 5'd0;
    at_check();
    chk("x0_rdata1", rdata1, 32'd0);
    next_cyc(); issue_valid = 1;
    at_check();
    chk("x0_done", {31'd0, wb_done}, 32'd0);
    chk("x0_ready", {31'd0, issue_ready}, 32'd1);

    // RAW stall
    next_cyc(); issue_valid = 1; issue_rd = 5'd3;
    at_check();
    chk("raw_issue_ready", {31'd0, issue_ready}, 32'd1);
    next_cyc(); raddr1 = 5'd3;
    at_check();
    chk("raw_stall", {31'd0, issue_ready}, 32'd0);
    next_cyc(); raddr1 = 5'd3; wb(5'd3, 32'h12345678);
    at_check();
    chk("raw_wb_ready", {31'd0, issue_ready}, BYP ? 32'd1 : 32'd0);
    chk("raw_wb_rdata1", rdata1, BYP ? 32'h12345678 : 32'd0);
    next_cyc(); raddr1 = 5'd3;
    at_check();
    chk("raw_after_ready", {31'd0, issue_ready}, 32'd1);
    chk("raw_after_rdata1", rdata1, 32'h12345678);

    // ecall
    next_cyc(); wb(5'd15, 32'hA5A5A5A5);
    next_cyc(); ecall = 1;
    at_check();
    chk("ecall_rdata2", rdata2, 32'hA5A5A5A5);
    chk("ecall_ready", {31'd0, issue_ready}, 32'd1);
    next_cyc(); issue_valid = 1; issue_rd = 5'd15;
    next_cyc(); ecall = 1;
    at_check();
    chk("ecall_busy_stall", {31'd0, issue_ready}, 32'd0);
    chk("ecall_busy_rdata2", rdata2, 32'hA5A5A5A5);
    next_cyc();
    at_check();
    chk("ecall_off_ready", {31'd0, issue_ready}, 32'd1);
    next_cyc(); wb(5'd15, 32'hA5A5A5A5);

    // same-cycle writeback and reservation
    next_cyc(); issue_valid = 1; issue_rd = 5'd7;
    next_cyc(); issue_valid = 1; issue_rd = 5'd7; wb(5'd7, 32'd1);
    at_check();
    chk("coll_ready", {31'd0, issue_ready}, BYP ? 32'd1 : 32'd0);
    next_cyc(); raddr1 = 5'd7;
    at_check();
    chk("coll_done", {31'd0, wb_done}, 32'd1);
    chk("coll_orphan", {31'd0, wb_orphan}, 32'd0);
    chk("coll_rdata1", rdata1, 32'd1);
    chk("coll_busy", {31'd0, issue_ready}, BYP ? 32'd0 : 32'd1);
    next_cyc(); wb(5'd7, 32'd1);
    at_check();
    chk("coll_done_drop", {31'd0, wb_done}, 32'd0);

    // orphan writeback
    next_cyc(); wb(5'd9, 32'h0000_9999);
    next_cyc(); raddr1 = 5'd9;
    at_check();
    chk("orph_done", {31'd0, wb_done}, 32'd1);
    chk("orph_orphan", {31'd0, wb_orphan}, 32'd1);
    chk("orph_rdata1", rdata1, 32'h0000_9999);
    next_cyc();
    at_check();
    chk("orph_done_drop", {31'd0, wb_done}, 32'd0);
    chk("orph_orphan_drop", {31'd0, wb_orphan}, 32'd0);

    // random traffic, addresses mostly in a small window to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      next_cyc();
      raddr1      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      raddr2      = 5'($urandom_range(0, 7));
      ecall       = ($urandom_range(0, 3) == 0);
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd    = ($urandom_range(0, 5) == 0) ? 5'd15 : 5'($urandom_range(0, 7));
      wb_valid    = ($urandom_range(0, 4) < 2);
      wb_addr     = ($urandom_range(0, 5) == 0) ? 5'd15 : 5'($urandom_range(0, 7));
      wb_data     = $urandom;
    end
    next_cyc();
    repeat (2) @(posedge clk);
    run_cmp = 1'b0;

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
